dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between two requesters:
//   - the RISC-V core load/store path;
//   - the Wishbone-side memory controller.
//  Replaces static core_select muxing with a request/ack arbiter, so both masters can run concurrently.
//  Sits between the core, the Wishbone memory-control FSM and the data_memory_wrapper memory port.
// PARAMETERS
//  ADDRESS_LENGTH  32  address width, all ports
//  DATA_LENGTH     32  data width, all ports
//  STARVE_LIMIT    4   max consecutive core grants while bus waits (fixed-priority mode); must be >=1
// PORTS
//  clk          in   1    clock, all state on rising edge
//  reset        in   1    asynchronous, active-low reset
//  core_rd_req  in   1    core read request, held until core_ack
//  core_wr_req  in   1    core write request, held until core_ack
//  core_addr    in   AL   core address
//  core_wdata   in   DL   core write data
//  core_len     in   2    core access length code (passed through)
//  core_rdata   out  DL   core read data, registered
//  core_ack     out  1    one-cycle completion pulse to core
//  bus_rd_req   in   1    Wishbone-side read request, held until bus_ack
//  bus_wr_req   in   1    Wishbone-side write request, held until bus_ack
//  bus_addr     in   AL   bus address
//  bus_wdata    in   DL   bus write data
//  bus_len      in   2    bus access length code
//  bus_rdata    out  DL   bus read data, registered
//  bus_ack      out  1    one-cycle completion pulse to bus side
//  mem_en       out  1    memory enable
//  mem_wr_en    out  1    memory write strobe
//  mem_rd_en    out  1    memory read strobe
//  mem_addr     out  AL   memory address
//  mem_wdata    out  DL   memory write data
//  mem_len      out  2    memory length code
//  mem_rdata    in   DL   memory read data, valid the cycle after mem_rd_en
//  grant        out  2    {bus,core} owner, one-hot or 0 when idle
//  proto_err    out  1    sticky: rd_req and wr_req asserted together by one requester
// BEHAVIOUR
//  - Reset (reset=0, async): FSM=IDLE; all outputs 0 (rdata regs included); starve count=0; last_served=bus.
//  - FSM: IDLE -> ACCESS -> WAIT -> DONE -> IDLE. ACCESS/WAIT/DONE each last exactly 1 cycle.
//  - IDLE: sample requests and pick a winner.
//    Winner's addr/wdata/len/type are registered and its grant bit is set. No request: stay in IDLE.
//  - ACCESS: mem_en=1 plus mem_wr_en or mem_rd_en. All mem_* outputs are registered and 0 outside ACCESS.
//  - WAIT: reads capture mem_rdata into the winner's rdata register at the end of this cycle.
//  - DONE: winner's ack=1 for exactly one cycle. grant clears on DONE->IDLE.
//  - Latency: request seen in cycle N -> mem strobe N+1 -> ack N+3. Throughput: one access per 4 cycles.
//  - Requester must drop its request on the edge that ends its ack cycle. A request present in IDLE is a new request.
//  - The loser's request stays pending untouched and is served on a later IDLE.
//  - Loser's ack and rdata are unaffected.
//  - rdata holds its value until that port's next read completes. Writes never alter rdata.
//  - rd_req and wr_req both high from one requester: the access is performed as a write and proto_err is set.
//    proto_err clears only on reset.
//  - Fixed priority (default):
//    - Core wins a simultaneous request.
//    - Each core grant made while bus_*_req is pending increments the starve count.
//    - When the count reaches STARVE_LIMIT, the next IDLE with the bus pending grants the bus.
//    - The count clears on any bus grant and on any IDLE with no bus request.
//  - Reset mid-operation aborts the access: no ack is issued, and the requester must re-request.
// CONFIGURATION
//  - ROUND_ROBIN_EN defined: simultaneous requests go to the requester not in last_served.
//    The starve counter and STARVE_LIMIT are unused.
//    last_served updates on every grant.
//  - ROUND_ROBIN_EN undefined: fixed priority with starvation limit as above.
// TESTING
//  - Core-only write, addr 0x10, data 0xDEADBEEF: mem_wr_en=1 for 1 cycle at N+1, core_ack at N+3, bus_ack stays 0.
//  - Bus-only read, addr 0x20, memory returns 0x12345678: bus_rdata=0x12345678 when bus_ack=1, core_rdata unchanged.
//  - Simultaneous core and bus reads, fixed priority: core acked first; bus mem strobe 4 cycles after core's.
//  - Core requests back-to-back, bus held, STARVE_LIMIT=4: grant order C,C,C,C,B.
//    With ROUND_ROBIN_EN: C,B,C,B.
//  - Core asserts rd_req and wr_req together: write performed, proto_err=1 and stays 1 until reset.
//  - reset low during WAIT: all outputs 0 immediately, no ack; after release, FSM in IDLE and serves a held request normally.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared data-memory port.
// The slave modport is the arbiter's view; master is the requesters/memory side.
// AL/DL must match the arbiter's ADDRESS_LENGTH/DATA_LENGTH.
interface dmem_port_arbiter_if #(
  parameter int AL = 32,
  parameter int DL = 32
);
  // core load/store path
  logic          core_rd_req;
  logic          core_wr_req;
  logic [AL-1:0] core_addr;
  logic [DL-1:0] core_wdata;
  logic [1:0]    core_len;
  logic [DL-1:0] core_rdata;
  logic          core_ack;
  // Wishbone-side memory controller
  logic          bus_rd_req;
  logic          bus_wr_req;
  logic [AL-1:0] bus_addr;
  logic [DL-1:0] bus_wdata;
  logic [1:0]    bus_len;
  logic [DL-1:0] bus_rdata;
  logic          bus_ack;
  // data memory port
  logic          mem_en;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [AL-1:0] mem_addr;
  logic [DL-1:0] mem_wdata;
  logic [1:0]    mem_len;
  logic [DL-1:0] mem_rdata;
  // status
  logic [1:0]    grant;
  logic          proto_err;

  modport slave (
    input  core_rd_req, core_wr_req, core_addr, core_wdata, core_len,
    output core_rdata, core_ack,
    input  bus_rd_req, bus_wr_req, bus_addr, bus_wdata, bus_len,
    output bus_rdata, bus_ack,
    output mem_en, mem_wr_en, mem_rd_en, mem_addr, mem_wdata, mem_len,
    input  mem_rdata,
    output grant, proto_err
  );

  modport master (
    output core_rd_req, core_wr_req, core_addr, core_wdata, core_len,
    input  core_rdata, core_ack,
    output bus_rd_req, bus_wr_req, bus_addr, bus_wdata, bus_len,
    input  bus_rdata, bus_ack,
    input  mem_en, mem_wr_en, mem_rd_en, mem_addr, mem_wdata, mem_len,
    output mem_rdata,
    input  grant, proto_err
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates core and Wishbone-side requests onto one data-memory port (IDLE/ACCESS/WAIT/DONE).
// Latency: request seen in cycle N -> mem strobe N+1 -> ack N+3; one access per 4 cycles.
// Backpressure: requests are held until ack; the loser waits untouched. ROUND_ROBIN_EN selects round-robin.
module dmem_port_arbiter #(
  parameter int ADDRESS_LENGTH = 32,
  parameter int DATA_LENGTH    = 32,
  parameter int STARVE_LIMIT   = 4
) (
  input logic               clk,
  input logic               reset,
  dmem_port_arbiter_if.slave port
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [1:0]                grant_q, grant_d;
  logic                      wr_q, wr_d;
  logic                      mem_en_q, mem_en_d;
  logic                      mem_wr_en_q, mem_wr_en_d;
  logic                      mem_rd_en_q, mem_rd_en_d;
  logic [ADDRESS_LENGTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_LENGTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [1:0]                mem_len_q, mem_len_d;
  logic [DATA_LENGTH-1:0]    core_rdata_q, core_rdata_d;
  logic [DATA_LENGTH-1:0]    bus_rdata_q, bus_rdata_d;
  logic                      core_ack_q, core_ack_d;
  logic                      bus_ack_q, bus_ack_d;
  logic                      proto_err_q, proto_err_d;

  logic core_req, bus_req, pick_bus, sel_wr, sel_both;

`ifdef ROUND_ROBIN_EN
  // 1 = bus was the most recent grant; ties go to the other side
  logic last_bus_q, last_bus_d;
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_q, starve_d;
`endif

  // Next-state: arbitration in IDLE, fixed-length access sequence afterwards
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    wr_d         = wr_q;
    mem_en_d     = 1'b0;
    mem_wr_en_d  = 1'b0;
    mem_rd_en_d  = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    mem_len_d    = '0;
    core_rdata_d = core_rdata_q;
    bus_rdata_d  = bus_rdata_q;
    core_ack_d   = 1'b0;
    bus_ack_d    = 1'b0;
    proto_err_d  = proto_err_q;
    core_req     = port.core_rd_req | port.core_wr_req;
    bus_req      = port.bus_rd_req | port.bus_wr_req;
`ifdef ROUND_ROBIN_EN
    last_bus_d   = last_bus_q;
    pick_bus     = bus_req & (~core_req | ~last_bus_q);
`else
    starve_d     = starve_q;
    pick_bus     = bus_req & (~core_req | (starve_q >= STARVE_MAX));
`endif
    sel_wr       = pick_bus ? port.bus_wr_req : port.core_wr_req;
    sel_both     = pick_bus ? (port.bus_rd_req & port.bus_wr_req)
                            : (port.core_rd_req & port.core_wr_req);

    case (state_q)
      S_IDLE: begin
`ifndef ROUND_ROBIN_EN
        // streak of core wins only counts while the bus is actually waiting
        if (!bus_req || pick_bus) starve_d = '0;
        else if (core_req && starve_q < STARVE_MAX) starve_d = starve_q + SW'(1);
`endif
        if (core_req || bus_req) begin
          state_d     = S_ACCESS;
          grant_d     = pick_bus ? 2'b10 : 2'b01;
          wr_d        = sel_wr;
          mem_en_d    = 1'b1;
          mem_wr_en_d = sel_wr;
          mem_rd_en_d = ~sel_wr;
          mem_addr_d  = pick_bus ? port.bus_addr  : port.core_addr;
          mem_wdata_d = pick_bus ? port.bus_wdata : port.core_wdata;
          mem_len_d   = pick_bus ? port.bus_len   : port.core_len;
          if (sel_both) proto_err_d = 1'b1;
`ifdef ROUND_ROBIN_EN
          last_bus_d  = pick_bus;
`endif
        end
      end
      S_ACCESS: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_DONE;
        if (!wr_q) begin
          if (grant_q[0]) core_rdata_d = port.mem_rdata;
          if (grant_q[1]) bus_rdata_d  = port.mem_rdata;
        end
        core_ack_d = grant_q[0];
        bus_ack_d  = grant_q[1];
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      wr_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_len_q    <= '0;
      core_rdata_q <= '0;
      bus_rdata_q  <= '0;
      core_ack_q   <= 1'b0;
      bus_ack_q    <= 1'b0;
      proto_err_q  <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_bus_q   <= 1'b1;
`else
      starve_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      wr_q         <= wr_d;
      mem_en_q     <= mem_en_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_len_q    <= mem_len_d;
      core_rdata_q <= core_rdata_d;
      bus_rdata_q  <= bus_rdata_d;
      core_ack_q   <= core_ack_d;
      bus_ack_q    <= bus_ack_d;
      proto_err_q  <= proto_err_d;
`ifdef ROUND_ROBIN_EN
      last_bus_q   <= last_bus_d;
`else
      starve_q     <= starve_d;
`endif
    end
  end

  assign port.grant      = grant_q;
  assign port.mem_en     = mem_en_q;
  assign port.mem_wr_en  = mem_wr_en_q;
  assign port.mem_rd_en  = mem_rd_en_q;
  assign port.mem_addr   = mem_addr_q;
  assign port.mem_wdata  = mem_wdata_q;
  assign port.mem_len    = mem_len_q;
  assign port.core_rdata = core_rdata_q;
  assign port.bus_rdata  = bus_rdata_q;
  assign port.core_ack   = core_ack_q;
  assign port.bus_ack    = bus_ack_q;
  assign port.proto_err  = proto_err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Random two-requester traffic against a transaction-level model of the arbiter.
// Each winner occupies the port for four cycles; expected outputs come from that schedule.
// A memory array answers reads one cycle after the strobe; reset is pulsed during WAIT.
module tb_dmem_port_arbiter;
  localparam int AL    = 32;
  localparam int DL    = 32;
  localparam int LIMIT = 4;
  localparam int NCYC  = 3000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.AL(AL), .DL(DL)) dif();

  dmem_port_arbiter #(
    .ADDRESS_LENGTH(AL),
    .DATA_LENGTH(DL),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .port (dif.slave)
  );

  int total = 0;
  int bad   = 0;
  int t     = 0;

  // requester agents: index 0 = core, 1 = bus
  logic          act[2];
  logic          rd[2];
  logic          wr[2];
  logic [AL-1:0] addr[2];
  logic [DL-1:0] wd[2];
  logic [1:0]    len[2];

  // transaction-level model
  int            acc_t  = -100;
  int            ack_t  = -100;
  int            free_t = 0;
  int            win    = 0;
  logic          m_wr   = 1'b0;
  logic [AL-1:0] m_addr = '0;
  logic [DL-1:0] m_wd   = '0;
  logic [1:0]    m_len  = '0;
  logic [DL-1:0] m_rval = '0;
  logic [DL-1:0] exp_rdata[2];
  logic          exp_perr = 1'b0;
  int            streak = 0;
  int            last_served = 1;
  logic [DL-1:0] ref_mem[16];

  // memory environment driven by the DUT's port
  logic [DL-1:0] env_mem[16];
  logic          rd_pending = 1'b0;
  logic [3:0]    rd_idx = '0;

  logic want_rst = 1'b0;
  logic rel      = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic in_acc;
    logic busy;
    in_acc = (t == acc_t);
    busy   = (t >= acc_t) && (t <= ack_t);
    if (t == ack_t && !m_wr) exp_rdata[win] = m_rval;
    chk("grant",      dif.grant,      busy ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00);
    chk("mem_en",     dif.mem_en,     in_acc);
    chk("mem_wr_en",  dif.mem_wr_en,  in_acc && m_wr);
    chk("mem_rd_en",  dif.mem_rd_en,  in_acc && !m_wr);
    chk("mem_addr",   dif.mem_addr,   in_acc ? m_addr : '0);
    chk("mem_wdata",  dif.mem_wdata,  in_acc ? m_wd : '0);
    chk("mem_len",    dif.mem_len,    in_acc ? m_len : 2'b00);
    chk("core_ack",   dif.core_ack,   (t == ack_t) && (win == 0));
    chk("bus_ack",    dif.bus_ack,    (t == ack_t) && (win == 1));
    chk("core_rdata", dif.core_rdata, exp_rdata[0]);
    chk("bus_rdata",  dif.bus_rdata,  exp_rdata[1]);
    chk("proto_err",  dif.proto_err,  exp_perr);
  endtask

  task automatic drive();
    dif.core_rd_req = act[0] & rd[0];
    dif.core_wr_req = act[0] & wr[0];
    dif.core_addr   = addr[0];
    dif.core_wdata  = wd[0];
    dif.core_len    = len[0];
    dif.bus_rd_req  = act[1] & rd[1];
    dif.bus_wr_req  = act[1] & wr[1];
    dif.bus_addr    = addr[1];
    dif.bus_wdata   = wd[1];
    dif.bus_len     = len[1];
  endtask

  task automatic model_reset();
    acc_t        = -100;
    ack_t        = -100;
    free_t       = t + 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    exp_perr     = 1'b0;
    streak       = 0;
    last_served  = 1;
    rd_pending   = 1'b0;
  endtask

  // new requests appear at random; an acked request is gone the cycle after its ack
  task automatic agents(input int pct, input bit allow_both);
    int k;
    for (int i = 0; i < 2; i++) begin
      if (act[i] && ack_t == t - 1 && win == i) act[i] = 1'b0;
      if (!act[i] && $urandom_range(99) < pct) begin
        k       = $urandom_range(15);
        act[i]  = 1'b1;
        rd[i]   = (k < 8) || (allow_both && k == 15);
        wr[i]   = (k >= 8);
        addr[i] = $urandom;
        wd[i]   = $urandom;
        len[i]  = 2'($urandom_range(3));
      end
    end
    drive();
  endtask

  // pick a winner whenever the port is free and someone is asking
  task automatic decide();
    int w;
    if (t < free_t) return;
`ifndef ROUND_ROBIN_EN
    if (!act[1]) streak = 0;
`endif
    if (!act[0] && !act[1]) return;
    if (!act[0]) w = 1;
    else if (!act[1]) w = 0;
    else begin
`ifdef ROUND_ROBIN_EN
      w = (last_served == 1) ? 0 : 1;
`else
      w = (streak >= LIMIT) ? 1 : 0;
`endif
    end
`ifdef ROUND_ROBIN_EN
    last_served = w;
`else
    if (w == 1) streak = 0;
    else if (act[1]) streak++;
`endif
    win    = w;
    acc_t  = t + 1;
    ack_t  = t + 3;
    free_t = t + 4;
    m_wr   = wr[w];
    m_addr = addr[w];
    m_wd   = wd[w];
    m_len  = len[w];
    if (rd[w] && wr[w]) exp_perr = 1'b1;
    if (m_wr) ref_mem[m_addr[5:2]] = m_wd;
    else m_rval = ref_mem[m_addr[5:2]];
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      env_mem[i] = ref_mem[i];
    end
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
      addr[i] = '0; wd[i] = '0; len[i] = '0;
      exp_rdata[i] = '0;
    end
    drive();
    dif.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    t = 0;
    check_outputs();
    reset  = 1'b1;
    free_t = 1;

    for (int n = 1; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      t = n;
      if (rel) begin
        reset = 1'b1;
        rel   = 1'b0;
      end
      check_outputs();

      // memory answers the read strobed last cycle, otherwise drives junk
      if (rd_pending) begin
        dif.mem_rdata = env_mem[rd_idx];
        rd_pending    = 1'b0;
      end else begin
        dif.mem_rdata = $urandom;
      end
      if (dif.mem_en && dif.mem_wr_en) env_mem[dif.mem_addr[5:2]] = dif.mem_wdata;
      if (dif.mem_en && dif.mem_rd_en) begin
        rd_pending = 1'b1;
        rd_idx     = dif.mem_addr[5:2];
      end

      if (n == 700 || n == 1700 || n == 2600) want_rst = 1'b1;
      if (want_rst && t == acc_t + 1) begin
        // abort during WAIT: outputs must clear at once and no ack follows
        want_rst = 1'b0;
        reset    = 1'b0;
        #1;
        model_reset();
        check_outputs();
        rel = 1'b1;
        continue;
      end

      if (n < 1000)      agents(30, 1'b0);
      else if (n < 2000) agents(100, 1'b0);
      else               agents(50, 1'b1);
      decide();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
